// File: rtl/cmp_window_stats.sv
// -----------------------------------------------------------------------------
// cmp_window_stats
//
// Windowed statistics collector placed after a 4-bit magnitude comparator.
// Each accepted sample brings the comparator operands (a, b) and its one-hot
// result (eq, gt, ls). Over a window of WINDOW accepted samples the block
// counts each outcome, counts malformed results, and tracks the largest
// operand gap among well-formed samples. When the window is full it presents
// one report record over a valid/ready handshake.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   clr        in   1   synchronous window abort (drops any pending report)
//   in_valid   in   1   sample present
//   in_ready   out  1   block can accept a sample
//   a, b       in   4   comparator operands, unsigned
//   eq/gt/ls   in   1   comparator result flags
//   out_valid  out  1   report record present
//   out_ready  in   1   consumer accepts the report
//   cnt_eq/cnt_gt/cnt_ls/cnt_err  out CW  per-outcome counts
//   max_gap    out  4   largest |a-b| among well-formed samples
// -----------------------------------------------------------------------------
module cmp_window_stats #(
    parameter  int WINDOW = 8,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    a,
    input  logic [3:0]    b,
    input  logic          eq,
    input  logic          gt,
    input  logic          ls,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_eq,
    output logic [CW-1:0] cnt_gt,
    output logic [CW-1:0] cnt_ls,
    output logic [CW-1:0] cnt_err,
    output logic [3:0]    max_gap
);

    typedef enum logic {ACCUM, REPORT} state_t;

    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_t        r_state,   w_state_nxt;
    logic [CW-1:0] r_cnt_eq,  w_cnt_eq_nxt;
    logic [CW-1:0] r_cnt_gt,  w_cnt_gt_nxt;
    logic [CW-1:0] r_cnt_ls,  w_cnt_ls_nxt;
    logic [CW-1:0] r_cnt_err, w_cnt_err_nxt;
    logic [CW-1:0] r_n,       w_n_nxt;
    logic [3:0]    r_max_gap, w_max_gap_nxt;

    logic          w_accept;
    logic          w_onehot;
    logic [3:0]    w_gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ACCUM;
            r_cnt_eq  <= '0;
            r_cnt_gt  <= '0;
            r_cnt_ls  <= '0;
            r_cnt_err <= '0;
            r_n       <= '0;
            r_max_gap <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_eq  <= w_cnt_eq_nxt;
            r_cnt_gt  <= w_cnt_gt_nxt;
            r_cnt_ls  <= w_cnt_ls_nxt;
            r_cnt_err <= w_cnt_err_nxt;
            r_n       <= w_n_nxt;
            r_max_gap <= w_max_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_eq_nxt  = r_cnt_eq;
        w_cnt_gt_nxt  = r_cnt_gt;
        w_cnt_ls_nxt  = r_cnt_ls;
        w_cnt_err_nxt = r_cnt_err;
        w_n_nxt       = r_n;
        w_max_gap_nxt = r_max_gap;

        w_accept = in_valid && (r_state == ACCUM) && !clr;

        unique case ({eq, gt, ls})
            3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
            default:                w_onehot = 1'b0;
        endcase

        // Gap follows the flags, not the operands: inconsistent operands
        // wrap modulo 16 rather than being re-compared here.
        if (gt)      w_gap = a - b;
        else if (ls) w_gap = b - a;
        else         w_gap = 4'd0;

        if (clr) begin
            w_state_nxt   = ACCUM;
            w_cnt_eq_nxt  = '0;
            w_cnt_gt_nxt  = '0;
            w_cnt_ls_nxt  = '0;
            w_cnt_err_nxt = '0;
            w_n_nxt       = '0;
            w_max_gap_nxt = '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_onehot) begin
                            if (eq) w_cnt_eq_nxt = r_cnt_eq + ONE_C;
                            if (gt) w_cnt_gt_nxt = r_cnt_gt + ONE_C;
                            if (ls) w_cnt_ls_nxt = r_cnt_ls + ONE_C;
                            if (w_gap > r_max_gap) w_max_gap_nxt = w_gap;
                        end else begin
                            w_cnt_err_nxt = r_cnt_err + ONE_C;
                        end
                        w_n_nxt = r_n + ONE_C;
                        if (r_n + ONE_C == WIN_C) w_state_nxt = REPORT;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        w_state_nxt   = ACCUM;
                        w_cnt_eq_nxt  = '0;
                        w_cnt_gt_nxt  = '0;
                        w_cnt_ls_nxt  = '0;
                        w_cnt_err_nxt = '0;
                        w_n_nxt       = '0;
                        w_max_gap_nxt = '0;
                    end
                end
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM) && !clr;
    assign out_valid = (r_state == REPORT);
    assign cnt_eq    = r_cnt_eq;
    assign cnt_gt    = r_cnt_gt;
    assign cnt_ls    = r_cnt_ls;
    assign cnt_err   = r_cnt_err;
    assign max_gap   = r_max_gap;

endmodule
